sr_latch_exerciser: RTL and testbench
=====================================

# sr_latch_exerciser

Synthesizable stimulus-and-check engine for a gated SR latch. On a start pulse it drives the latch's `enable`, `R` and `S` inputs through a fixed 8-step set/hold/reset/hold sequence and samples `Q`/`Q_n` at the end of each step. It compares each sample against an internal reference model, counts mismatches and reports pass/fail. It sits on the driving side of the latch, in place of a behavioural bench, so the latch can be exercised on hardware.

## Interface
- `HOLD_CYCLES`, default 4: clock cycles each step is held. Legal range 4–255; values below 4 are unsupported.

- `clk`  input  1  single system clock, rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `start`  input  1  begin a run; sampled only in IDLE.
- `enable`  output  1  latch gate, registered.
- `R`  output  1  latch reset input, registered.
- `S`  output  1  latch set input, registered.
- `Q`  input  1  latch output, asynchronous to `clk`.
- `Q_n`  input  1  latch complementary output, asynchronous to `clk`.
- `busy`  output  1  high while a run is in progress.
- `done`  output  1  one-cycle pulse at end of run.
- `pass`  output  1  1 = last run had zero mismatches; held until next start.
- `err_count`  output  4  mismatches in the current or last run, 0–8.
- `step`  output  3  index of the step currently driven.

## Operation
- FSM states:
  - IDLE → RUN on `start`=1.
  - RUN → IDLE after the step-7 sample.
  - In IDLE, `enable`/`R`/`S` = 0.
- Step vectors (`enable`,`R`,`S`) → expected Q:
  - step 0: 1,0,1 → 1
  - step 1: 0,0,1 → 1
  - step 2: 1,0,0 → 1
  - step 3: 0,0,0 → 1
  - step 4: 1,1,0 → 0
  - step 5: 0,1,0 → 0
  - step 6: 1,0,0 → 0
  - step 7: 0,0,0 → 0
- Reference model: a gated SR latch state bit.
  - Updated when each step's vector is loaded.
  - With `enable`=1: S sets it, R clears it, R=S=0 holds it.
  - With `enable`=0: it holds.
  - The model is cleared to 0 on start.
- `Q` and `Q_n` each pass through a 2-flop synchronizer before comparison.
- Mismatch condition: synchronized Q ≠ expected, OR synchronized `Q_n` ≠ ~expected. At most one mismatch is counted per step.
- `err_count`:
  - Cleared to 0 on start.
  - Increments by 1 per mismatching step.
  - Cannot exceed 8 (4-bit width suffices; no wrap).
- `start` while `busy` is ignored; the run is not restarted.
- `rst_n` low, including mid-run:
  - Immediately `enable`=`R`=`S`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `step`=0.
  - State = IDLE; synchronizers and model cleared.
  - After release, the block waits for a new `start`.

## Timing
- Reset values: all outputs 0.
- Edge E0 is the edge sampling `start`=1 in IDLE. At E0:
  - State ← RUN, `busy` ← 1, `step` ← 0, cycle counter ← 0.
  - `enable`/`R`/`S` ← step-0 vector.
- Cycle counter behaviour:
  - Increments every edge in RUN.
  - At the edge where counter = HOLD_CYCLES−1, the synchronized Q/`Q_n` are compared and `err_count` is updated at that edge.
  - At that same edge, if `step` < 7: `step` increments, counter ← 0, and the next vector is loaded.
- Step k vector is therefore driven from E0 + k·HOLD_CYCLES until E0 + (k+1)·HOLD_CYCLES.
- Sampling window: the compared value reflects latch output at edge (sample−2), i.e. ≥ HOLD_CYCLES−2 cycles after the vector changed. Latch settling must be shorter than that.
- At the step-7 sample edge, E0 + 8·HOLD_CYCLES:
  - State ← IDLE, `busy` ← 0, `done` ← 1 for exactly one cycle.
  - `enable`/`R`/`S` ← 0.
  - `pass` ← 1 if the final `err_count` (including step 7) is 0, else `pass` ← 0.
  - `step` holds 7 until next start.
- `start` coincident with the `done` edge is ignored; state was RUN. The earliest accepted restart is the next edge.
- Run length: 8·HOLD_CYCLES cycles from E0 to the `done` edge.

## Test plan
- Correct latch model, HOLD_CYCLES=4, one `start` pulse:
  - `enable`/`R`/`S` follow the 8 vectors at 4-cycle spacing.
  - `done` pulses at E0+32.
  - `pass`=1, `err_count`=0.
- Q stuck at 0, `Q_n` stuck at 1:
  - Steps 0–3 mismatch.
  - At `done`: `err_count`=4, `pass`=0.
- Q and `Q_n` both tied 1:
  - Every step mismatches.
  - `err_count`=8, `pass`=0, no wrap.
- `start` re-pulsed at E0+10 during a correct run:
  - The run is unaffected; `done` still at E0+32.
  - Then a second `start` gives a fresh run with `err_count` cleared and `pass` cleared at the new E0.
- `rst_n` asserted asynchronously at E0+13 (mid-step 3):
  - All outputs 0 immediately, without waiting for a clock.
  - No `done` pulse.
  - After release, `start` produces a full clean run from step 0.
- HOLD_CYCLES=6 with a latch model having a 3-cycle output delay:
  - Run length 48 cycles; `pass`=1.
  - The same model with HOLD_CYCLES=4 gives `err_count`>0.

Source files
------------

// File: rtl/sr_latch_exerciser.sv
`default_nettype none
// ============================================================================
//  Module      : sr_latch_exerciser
//  Description : Stimulus-and-check engine for a gated SR latch. Steps the
//                latch through an 8-vector set/hold/reset/hold sequence,
//                samples synchronized Q/Q_n at the end of every step, compares
//                against a reference latch model and reports pass/fail.
//  Revision    : 1.0 - initial release
// ============================================================================
module sr_latch_exerciser #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       enable,
    output logic       R,
    output logic       S,
    input  logic       Q,
    input  logic       Q_n,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] step
);

    localparam logic [2:0] c_LAST_STEP = 3'd7;
    localparam logic [7:0] c_HOLD_LAST = 8'(HOLD_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t     r_state;
    logic [7:0] r_cnt;
    logic       r_model;
    logic       r_q_s1;
    logic       r_q_s2;
    logic       r_qn_s1;
    logic       r_qn_s2;

    logic [2:0] w_next_step;
    logic [2:0] w_next_vec;
    logic [2:0] w_first_vec;
    logic       w_sample;
    logic       w_mismatch;
    logic [3:0] w_err_next;

    // Vector for each step, packed as {enable, R, S}.
    function automatic logic [2:0] f_step_vec(input logic [2:0] idx);
        logic [2:0] v;
        case (idx)
            3'd0:    v = 3'b101;
            3'd1:    v = 3'b001;
            3'd2:    v = 3'b100;
            3'd3:    v = 3'b000;
            3'd4:    v = 3'b110;
            3'd5:    v = 3'b010;
            3'd6:    v = 3'b100;
            default: v = 3'b000;
        endcase
        return v;
    endfunction

    // Gated SR latch next state for a given {enable, R, S} vector.
    function automatic logic f_latch(input logic cur, input logic [2:0] vec);
        logic nxt;
        nxt = cur;
        if (vec[2]) begin
            if (vec[0])
                nxt = 1'b1;
            else if (vec[1])
                nxt = 1'b0;
        end
        return nxt;
    endfunction

    assign w_next_step = step + 3'd1;
    assign w_next_vec  = f_step_vec(w_next_step);
    assign w_first_vec = f_step_vec(3'd0);
    assign w_sample    = (r_cnt == c_HOLD_LAST);
    assign w_mismatch  = (r_q_s2 != r_model) || (r_qn_s2 != ~r_model);
    assign w_err_next  = err_count + {3'b000, w_mismatch};

    // Two-flop synchronizers for the latch outputs, which are asynchronous to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_s1  <= 1'b0;
            r_q_s2  <= 1'b0;
            r_qn_s1 <= 1'b0;
            r_qn_s2 <= 1'b0;
        end else begin
            r_q_s1  <= Q;
            r_q_s2  <= r_q_s1;
            r_qn_s1 <= Q_n;
            r_qn_s2 <= r_qn_s1;
        end
    end

    // Run controller: step sequencing, reference model, error counting and status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 8'd0;
            r_model   <= 1'b0;
            enable    <= 1'b0;
            R         <= 1'b0;
            S         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 4'd0;
            step      <= 3'd0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state          <= ST_RUN;
                        busy             <= 1'b1;
                        step             <= 3'd0;
                        r_cnt            <= 8'd0;
                        {enable, R, S}   <= w_first_vec;
                        // Model starts cleared, then takes the step-0 vector.
                        r_model          <= f_latch(1'b0, w_first_vec);
                        err_count        <= 4'd0;
                        pass             <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (w_sample) begin
                        err_count <= w_err_next;
                        if (step == c_LAST_STEP) begin
                            r_state        <= ST_IDLE;
                            busy           <= 1'b0;
                            done           <= 1'b1;
                            {enable, R, S} <= 3'b000;
                            pass           <= (w_err_next == 4'd0);
                        end else begin
                            step           <= w_next_step;
                            r_cnt          <= 8'd0;
                            {enable, R, S} <= w_next_vec;
                            r_model        <= f_latch(r_model, w_next_vec);
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sr_latch_exerciser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sr_latch_exerciser
//  Description : Self-checking bench for sr_latch_exerciser with behavioural
//                gated SR latch models (ideal, faulty and delayed).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_latch_exerciser;

    typedef struct {
        logic [3:0] err;
        logic       pass;
        int         len;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start4;
    logic       start6;
    logic       en4, r4, s4, q4, qn4, busy4, done4, pass4;
    logic       en6, r6, s6, busy6, done6, pass6;
    logic [3:0] err4, err6;
    logic [2:0] step4, step6;
    logic       lat4 = 1'b0;
    logic       lat6 = 1'b0;
    logic [2:0] r_d4 = 3'b000;
    logic [2:0] r_d6 = 3'b000;
    int         r_mode = 0;
    logic       r_sel  = 1'b0;
    int         n_chk  = 0;
    int         n_fail = 0;
    exp_t       sb[$];
    logic [2:0] vec_tab [8];

    logic       w_busy, w_done, w_pass;
    logic [3:0] w_err;
    logic [2:0] w_step, w_vec;

    always #5 clk = ~clk;

    sr_latch_exerciser #(.HOLD_CYCLES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4),
        .enable(en4), .R(r4), .S(s4), .Q(q4), .Q_n(qn4),
        .busy(busy4), .done(done4), .pass(pass4),
        .err_count(err4), .step(step4)
    );

    sr_latch_exerciser #(.HOLD_CYCLES(6)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .start(start6),
        .enable(en6), .R(r6), .S(s6), .Q(r_d6[2]), .Q_n(~r_d6[2]),
        .busy(busy6), .done(done6), .pass(pass6),
        .err_count(err6), .step(step6)
    );

    // Behavioural gated SR latches driven by each DUT.
    always @* begin
        if (en4) begin
            if (s4) lat4 = 1'b1;
            else if (r4) lat4 = 1'b0;
        end
    end

    always @* begin
        if (en6) begin
            if (s6) lat6 = 1'b1;
            else if (r6) lat6 = 1'b0;
        end
    end

    // Three-cycle output delay for the slow-latch scenario.
    always @(posedge clk) begin
        r_d4 <= {r_d4[1:0], lat4};
        r_d6 <= {r_d6[1:0], lat6};
    end

    // Latch output selection for the HOLD_CYCLES=4 instance.
    always_comb begin
        q4  = lat4;
        qn4 = ~lat4;
        case (r_mode)
            1: begin q4 = 1'b0;    qn4 = 1'b1;     end
            2: begin q4 = 1'b1;    qn4 = 1'b1;     end
            3: begin q4 = r_d4[2]; qn4 = ~r_d4[2]; end
            default: ;
        endcase
    end

    assign w_busy = r_sel ? busy6 : busy4;
    assign w_done = r_sel ? done6 : done4;
    assign w_pass = r_sel ? pass6 : pass4;
    assign w_err  = r_sel ? err6  : err4;
    assign w_step = r_sel ? step6 : step4;
    assign w_vec  = r_sel ? {en6, r6, s6} : {en4, r4, s4};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // One complete run: expectation pushed at stimulus, popped at done.
    task automatic run_one(input logic sel, input int mode, input logic [3:0] e_err,
                           input logic e_pass, input int h, input bit repulse);
        exp_t e;
        int   cyc;
        r_sel  = sel;
        r_mode = mode;
        repeat (4) @(negedge clk);
        e.err  = e_err;
        e.pass = e_pass;
        e.len  = 8 * h;
        sb.push_back(e);
        if (sel) start6 = 1'b1;
        else     start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        start6 = 1'b0;
        cyc    = 0;
        check("busy_at_E0", 32'(w_busy), 32'd1);
        check("err_clear_E0", 32'(w_err), 32'd0);
        check("pass_clear_E0", 32'(w_pass), 32'd0);
        check("vec_step0", 32'(w_vec), 32'(vec_tab[0]));
        while (cyc < 400) begin
            @(posedge clk);
            cyc++;
            #1;
            if (repulse) start4 = (cyc == 9);
            if (w_done) break;
            if ((cyc % h == 2) && (cyc / h < 8))
                check("vec_step", 32'(w_vec), 32'(vec_tab[cyc / h]));
        end
        start4 = 1'b0;
        e = sb.pop_front();
        check("run_len", 32'(cyc), 32'(e.len));
        check("err_count", 32'(w_err), 32'(e.err));
        check("pass", 32'(w_pass), 32'(e.pass));
        check("vec_idle", 32'(w_vec), 32'd0);
        check("step_hold7", 32'(w_step), 32'd7);
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(w_done), 32'd0);
        check("busy_off", 32'(w_busy), 32'd0);
    endtask

    initial begin
        vec_tab = '{3'b101, 3'b001, 3'b100, 3'b000, 3'b110, 3'b010, 3'b100, 3'b000};
        rst_n  = 1'b0;
        start4 = 1'b0;
        start6 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs4", 32'({en4, r4, s4, busy4, done4, pass4, err4, step4}), 32'd0);
        check("reset_outputs6", 32'({en6, r6, s6, busy6, done6, pass6, err6, step6}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_one(1'b0, 0, 4'd0, 1'b1, 4, 1'b0);  // ideal latch
        run_one(1'b0, 1, 4'd4, 1'b0, 4, 1'b0);  // Q stuck 0, Q_n stuck 1
        run_one(1'b0, 2, 4'd8, 1'b0, 4, 1'b0);  // both outputs tied 1
        run_one(1'b0, 0, 4'd0, 1'b1, 4, 1'b1);  // start re-pulsed mid-run
        run_one(1'b0, 0, 4'd0, 1'b1, 4, 1'b0);  // fresh run clears pass at E0
        run_one(1'b0, 3, 4'd2, 1'b0, 4, 1'b0);  // slow latch, hold too short
        run_one(1'b1, 0, 4'd0, 1'b1, 6, 1'b0);  // slow latch, hold of 6

        // Asynchronous reset in the middle of step 3.
        r_sel  = 1'b0;
        r_mode = 0;
        repeat (4) @(negedge clk);
        start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        repeat (13) @(posedge clk);
        #3;
        check("step_before_reset", 32'(step4), 32'd3);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'({en4, r4, s4, busy4, done4, pass4, err4, step4}), 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("no_done_in_reset", 32'(done4), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("idle_after_reset", 32'({busy4, done4, en4, r4, s4}), 32'd0);
        end
        run_one(1'b0, 0, 4'd0, 1'b1, 4, 1'b0);  // clean run after reset

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
